rd_xfer_arbiter: RTL and testbench
==================================

RD_XFER_ARBITER -- requirements
Module: rd_xfer_arbiter

Interface
REQ-001 Parameter SETUP_CYCLES, default 4, range 2..15: cycles XFER_DATA/XFER_TAG are held stable before XFER_TOG toggles.
REQ-002 Parameter TIMEOUT, default 1023, range 16..1023: max cycles in WAIT_ACK before abort.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RSTN  input  1  reset, synchronous, active-low.
REQ-005 ENABLE  input  1  high = new grants allowed.
REQ-006 REQ  input  4  level request per requester; held until its DONE or ERR pulse.
REQ-007 DATA  input  128  requester i word on DATA[32*i+31:32*i]; stable while REQ[i] high.
REQ-008 XFER_ACK  input  1  acknowledge toggle from far domain, already synchronized to CLK.
REQ-009 XFER_DATA  output  32  word presented to the 32-bit synchronizer channel.
REQ-010 XFER_TAG  output  2  index of requester owning XFER_DATA.
REQ-011 XFER_TOG  output  1  request toggle; one edge per transfer.
REQ-012 DONE  output  4  one-cycle completion pulse per requester.
REQ-013 ERR  output  4  one-cycle timeout pulse per requester.
REQ-014 BUSY  output  1  high in every state except IDLE.

Function
REQ-015 States IDLE, SETUP, WAIT_ACK, FINISH; registered outputs only.
REQ-016 IDLE: if ENABLE and any REQ bit set, grant round-robin starting at index (LAST+1) mod 4, LAST = last granted index; go SETUP.
REQ-017 Grant cycle: DATA word of winner loaded into XFER_DATA, index into XFER_TAG and LAST, setup counter cleared; both visible the cycle SETUP is entered.
REQ-018 XFER_DATA and XFER_TAG change only on a grant; held unchanged through SETUP, WAIT_ACK, FINISH and following IDLE cycles.
REQ-019 SETUP: counter increments each cycle; after exactly SETUP_CYCLES cycles in SETUP, XFER_TOG inverts and state goes WAIT_ACK with timeout counter cleared.
REQ-020 WAIT_ACK: XFER_ACK == XFER_TOG -> DONE[XFER_TAG] high next cycle, state FINISH.
REQ-021 WAIT_ACK: timeout counter reaches TIMEOUT with no match -> ERR[XFER_TAG] high next cycle, state FINISH; XFER_TOG not restored.
REQ-022 Match and timeout in same cycle: match wins, DONE only.
REQ-023 FINISH lasts exactly one cycle (the DONE/ERR pulse cycle), then IDLE; minimum one IDLE cycle between transfers, so REQ[i] still high in that pulse cycle is not re-granted.
REQ-024 Request deasserted after grant: transfer still completes; DONE/ERR still pulses.
REQ-025 ENABLE low: no new grants; transfer in progress completes normally.
REQ-026 XFER_ACK changes outside WAIT_ACK are ignored; late ack after timeout cannot complete the next transfer, since that transfer toggles XFER_TOG again.
REQ-027 Latency: grant at IDLE cycle t -> XFER_TOG edge at t+1+SETUP_CYCLES; ack match seen cycle a -> DONE at a+1.
REQ-028 Counters saturate, never wrap: setup counter 4 bits, timeout counter 10 bits.
REQ-029 At most one DONE or ERR bit high in any cycle; never both.

Reset
REQ-030 RSTN low at a rising edge: state IDLE, XFER_DATA=0, XFER_TAG=0, XFER_TOG=0, DONE=0, ERR=0, BUSY=0, LAST=3 so the first grant goes to requester 0.
REQ-031 Reset mid-transfer aborts without DONE/ERR pulse; first post-reset transfer drives XFER_TOG 0->1.

Verification
REQ-032 Single transfer: REQ=0001, DATA[31:0]=0xDEADBEEF, ack looped back after 3 cycles -> XFER_DATA=0xDEADBEEF, TAG=0, TOG 0->1 after 4 SETUP cycles, DONE=0001 one cycle, BUSY low after.
REQ-033 Round robin: REQ=1111 held, immediate ack -> grant order 0,1,2,3,0; each DATA word appears on XFER_DATA with matching TAG.
REQ-034 Timeout: REQ=0100, XFER_ACK tied 0 -> ERR=0100 after 1023 WAIT_ACK cycles, no DONE; next transfer TOG 1->0, completes with ack=0.
REQ-035 Stability: random DATA changes while REQ low, ack delays 0..50 -> XFER_DATA never changes between grants; every toggle preceded by >=4 stable cycles.
REQ-036 Reset mid-WAIT_ACK with REQ=0010 -> all outputs 0 next cycle, no pulse; after release first grant to requester 1 (lowest requesting index, starting at 0).
REQ-037 ENABLE dropped during SETUP with REQ=1010 -> current transfer completes with DONE, no further grant until ENABLE high.

Source files
------------

// File: rtl/rd_xfer_arbiter_if.sv
// Bundle of request-side and synchronizer-side signals for rd_xfer_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the logic that drives requests and the far-domain acknowledge.
interface rd_xfer_arbiter_if;
  logic         ENABLE;
  logic [3:0]   REQ;
  logic [127:0] DATA;
  logic         XFER_ACK;
  logic [31:0]  XFER_DATA;
  logic [1:0]   XFER_TAG;
  logic         XFER_TOG;
  logic [3:0]   DONE;
  logic [3:0]   ERR;
  logic         BUSY;

  modport slave (
    input  ENABLE, REQ, DATA, XFER_ACK,
    output XFER_DATA, XFER_TAG, XFER_TOG, DONE, ERR, BUSY
  );

  modport master (
    output ENABLE, REQ, DATA, XFER_ACK,
    input  XFER_DATA, XFER_TAG, XFER_TOG, DONE, ERR, BUSY
  );
endinterface

// File: rtl/rd_xfer_arbiter.sv
// Round-robin arbiter feeding four requesters into one 32-bit toggle-handshake
// synchronizer channel. A winner's word and tag are launched, held for
// SETUP_CYCLES, then the request toggle flips and the arbiter waits for the
// far side's ack toggle to match (DONE) or for the timeout to expire (ERR).
module rd_xfer_arbiter #(
  parameter int SETUP_CYCLES = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic               CLK,
  input  logic               RSTN,
  rd_xfer_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    FINISH   = 2'd3
  } state_t;

  // Setup counter value in the last SETUP cycle.
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
  // Timeout counter value in the TIMEOUT-th WAIT_ACK cycle (counter starts at 0).
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  state_t      state_reg;
  logic [31:0] xfer_data_reg;
  logic [1:0]  xfer_tag_reg;
  logic        xfer_tog_reg;
  logic [3:0]  done_reg;
  logic [3:0]  err_reg;
  logic        busy_reg;
  logic [1:0]  last_reg;
  logic [3:0]  setup_cnt_reg;
  logic [9:0]  tmo_cnt_reg;

  logic [31:0] req_word [4];
  logic        grant_found;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;

  // Split the flat data bus into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign req_word[gi] = bus.DATA[32*gi +: 32];
    end
  endgenerate

  // Round-robin pick: first requesting index at or after last_reg+1 (mod 4).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last_reg + 2'(k + 1);
      if (!grant_found && bus.REQ[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_reg     <= IDLE;
      xfer_data_reg <= 32'd0;
      xfer_tag_reg  <= 2'd0;
      xfer_tog_reg  <= 1'b0;
      done_reg      <= 4'd0;
      err_reg       <= 4'd0;
      busy_reg      <= 1'b0;
      last_reg      <= 2'd3;
      setup_cnt_reg <= 4'd0;
      tmo_cnt_reg   <= 10'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.ENABLE && grant_found) begin
            xfer_data_reg <= req_word[grant_idx];
            xfer_tag_reg  <= grant_idx;
            last_reg      <= grant_idx;
            setup_cnt_reg <= 4'd0;
            busy_reg      <= 1'b1;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt_reg == SETUP_LAST) begin
            xfer_tog_reg <= ~xfer_tog_reg;
            tmo_cnt_reg  <= 10'd0;
            state_reg    <= WAIT_ACK;
          end else if (setup_cnt_reg != 4'hF) begin
            setup_cnt_reg <= setup_cnt_reg + 4'd1;
          end
        end
        WAIT_ACK: begin
          // A match beats a simultaneous timeout.
          if (bus.XFER_ACK == xfer_tog_reg) begin
            done_reg  <= 4'b0001 << xfer_tag_reg;
            state_reg <= FINISH;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            err_reg   <= 4'b0001 << xfer_tag_reg;
            state_reg <= FINISH;
          end else if (tmo_cnt_reg != 10'h3FF) begin
            tmo_cnt_reg <= tmo_cnt_reg + 10'd1;
          end
        end
        FINISH: begin
          // One pulse cycle, then back to IDLE without granting here.
          done_reg  <= 4'd0;
          err_reg   <= 4'd0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.XFER_DATA = xfer_data_reg;
  assign bus.XFER_TAG  = xfer_tag_reg;
  assign bus.XFER_TOG  = xfer_tog_reg;
  assign bus.DONE      = done_reg;
  assign bus.ERR       = err_reg;
  assign bus.BUSY      = busy_reg;

endmodule

// File: tb/tb_rd_xfer_arbiter.sv
// Directed self-checking bench for rd_xfer_arbiter: single transfer,
// round robin, timeout, data stability with random ack delays, reset
// mid-transfer and ENABLE drop during SETUP.
module tb_rd_xfer_arbiter;
  localparam int SC = 4;
  localparam int TO = 1023;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  rd_xfer_arbiter_if bus ();

  rd_xfer_arbiter #(.SETUP_CYCLES(SC), .TIMEOUT(TO)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  int          pass_cnt  = 0;
  int          fail_cnt  = 0;
  int          total_cnt = 0;
  logic        exp_tog   = 1'b0;
  logic [31:0] last_data = 32'd0;
  logic [31:0] words [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    bus.DATA = {words[3], words[2], words[1], words[0]};
  endtask

  // Runs one transfer starting from an IDLE cycle with the winner's REQ set.
  // ack_delay = WAIT_ACK cycles before the ack is looped back.
  task automatic do_xfer(input int idx, input int ack_delay, input bit drop_en);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    tick();
    last_data = words[idx];
    check("grant_tag", 32'(bus.XFER_TAG), 32'(idx));
    check("grant_data", bus.XFER_DATA, last_data);
    check("grant_busy", 32'(bus.BUSY), 32'd1);
    if (drop_en) bus.ENABLE = 1'b0;
    repeat (SC - 1) tick();
    check("setup_tog_held", 32'(bus.XFER_TOG), 32'(exp_tog));
    check("setup_data_held", bus.XFER_DATA, last_data);
    tick();
    exp_tog = ~exp_tog;
    check("tog_edge", 32'(bus.XFER_TOG), 32'(exp_tog));
    for (int d = 0; d < ack_delay; d++) begin
      tick();
      check("wait_no_done", 32'(bus.DONE), 32'd0);
    end
    bus.XFER_ACK = exp_tog;
    tick();
    $display("xfer idx=%0d delay=%0d data=%08h tog=%0b done=%04b", idx, ack_delay,
             bus.XFER_DATA, bus.XFER_TOG, bus.DONE);
    check("done_pulse", 32'(bus.DONE), 32'(onehot));
    check("done_no_err", 32'(bus.ERR), 32'd0);
    tick();
    check("done_clear", 32'(bus.DONE), 32'd0);
    check("idle_busy", 32'(bus.BUSY), 32'd0);
    check("idle_data_held", bus.XFER_DATA, last_data);
  endtask

  initial begin
    int idx;
    bus.ENABLE   = 1'b0;
    bus.REQ      = 4'd0;
    bus.XFER_ACK = 1'b0;
    for (int i = 0; i < 4; i++) words[i] = 32'd0;
    set_data();

    // Reset state.
    rstn = 1'b0;
    tick();
    tick();
    check("rst_data", bus.XFER_DATA, 32'd0);
    check("rst_tag", 32'(bus.XFER_TAG), 32'd0);
    check("rst_tog", 32'(bus.XFER_TOG), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_err", 32'(bus.ERR), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);

    // Single transfer, ack after 3 WAIT_ACK cycles.
    rstn = 1'b1;
    words[0] = 32'hDEADBEEF;
    set_data();
    bus.REQ    = 4'b0001;
    bus.ENABLE = 1'b1;
    do_xfer(0, 3, 1'b0);
    bus.REQ = 4'd0;
    tick();
    check("single_idle_busy", 32'(bus.BUSY), 32'd0);
    check("single_data_kept", bus.XFER_DATA, 32'hDEADBEEF);

    // Round robin from reset: 0,1,2,3,0 with immediate ack.
    rstn = 1'b0;
    bus.XFER_ACK = 1'b0;
    tick();
    rstn = 1'b1;
    exp_tog = 1'b0;
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    set_data();
    bus.REQ = 4'b1111;
    for (int i = 0; i < 5; i++) do_xfer(i % 4, 0, 1'b0);
    bus.REQ = 4'd0;

    // Timeout with ack tied low, then a normal transfer with ack still low.
    rstn = 1'b0;
    bus.XFER_ACK = 1'b0;
    tick();
    rstn = 1'b1;
    exp_tog = 1'b0;
    bus.REQ = 4'b0100;
    tick();
    check("tmo_grant_tag", 32'(bus.XFER_TAG), 32'd2);
    repeat (SC) tick();
    exp_tog = 1'b1;
    check("tmo_tog", 32'(bus.XFER_TOG), 32'd1);
    repeat (TO - 1) tick();
    check("tmo_err_early", 32'(bus.ERR), 32'd0);
    check("tmo_busy", 32'(bus.BUSY), 32'd1);
    tick();
    $display("timeout err=%04b done=%04b", bus.ERR, bus.DONE);
    check("tmo_err", 32'(bus.ERR), 32'b0100);
    check("tmo_no_done", 32'(bus.DONE), 32'd0);
    tick();
    check("tmo_err_clear", 32'(bus.ERR), 32'd0);
    check("tmo_idle", 32'(bus.BUSY), 32'd0);
    check("tmo_tog_kept", 32'(bus.XFER_TOG), 32'd1);
    do_xfer(2, 0, 1'b0);
    bus.REQ = 4'd0;

    // Stability: data churns while REQ low, random ack delays.
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        set_data();
        tick();
        check("stab_idle_data", bus.XFER_DATA, last_data);
      end
      idx = $urandom_range(0, 3);
      bus.REQ = 4'b0001 << idx;
      do_xfer(idx, $urandom_range(0, 50), 1'b0);
      bus.REQ = 4'd0;
    end

    // Reset in the middle of WAIT_ACK.
    bus.REQ = 4'b0010;
    tick();
    check("mid_grant_tag", 32'(bus.XFER_TAG), 32'd1);
    repeat (SC + 2) tick();
    rstn = 1'b0;
    tick();
    check("mid_rst_data", bus.XFER_DATA, 32'd0);
    check("mid_rst_tag", 32'(bus.XFER_TAG), 32'd0);
    check("mid_rst_tog", 32'(bus.XFER_TOG), 32'd0);
    check("mid_rst_done", 32'(bus.DONE), 32'd0);
    check("mid_rst_err", 32'(bus.ERR), 32'd0);
    check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    rstn = 1'b1;
    bus.XFER_ACK = 1'b0;
    exp_tog = 1'b0;
    do_xfer(1, 2, 1'b0);
    bus.REQ = 4'd0;

    // ENABLE dropped during SETUP with REQ=1010 (last granted was 1).
    bus.REQ = 4'b1010;
    do_xfer(3, 2, 1'b1);
    repeat (3) tick();
    check("en_low_busy", 32'(bus.BUSY), 32'd0);
    check("en_low_tag", 32'(bus.XFER_TAG), 32'd3);
    bus.ENABLE = 1'b1;
    do_xfer(1, 1, 1'b0);
    bus.REQ = 4'd0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
